// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_pkg
// Description : Shared widths, saturation limits and the result-beat record
//               for the adder result stage.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

    localparam int ADDER_WIDTH = 32;

    localparam logic [ADDER_WIDTH-1:0] SAT_MAX = {1'b0, {(ADDER_WIDTH-1){1'b1}}};
    localparam logic [ADDER_WIDTH-1:0] SAT_MIN = {1'b1, {(ADDER_WIDTH-1){1'b0}}};

    typedef struct packed {
        logic [ADDER_WIDTH-1:0] result;
        logic                   cout;
        logic                   overflow;
        logic                   zero;
        logic                   neg;
        logic                   sat;
    } result_beat_t;

    localparam int BEAT_W = $bits(result_beat_t);

endpackage
`default_nettype wire

// File: rtl/result_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : result_skid_buffer
// Description : Generic 2-entry valid/ready skid buffer; ready is registered.
// Revision    : 1.0 - initial release
// ============================================================================
module result_skid_buffer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic              m_valid_q, m_valid_d;
    logic              s_valid_q, s_valid_d;
    logic              ready_q;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;
    logic              w_accept;
    logic              w_drain;

    assign w_accept = in_valid & ready_q;
    assign w_drain  = m_valid_q & out_ready;

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        if (s_valid_q) begin
            // ready is low while S is full, so only a drain can move things
            if (w_drain) begin
                m_data_d  = s_data_q;
                s_valid_d = 1'b0;
            end
        end else if (w_accept) begin
            if (!m_valid_q || out_ready) begin
                m_data_d  = in_data;
                m_valid_d = 1'b1;
            end else begin
                s_data_d  = in_data;
                s_valid_d = 1'b1;
            end
        end else if (w_drain) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            s_valid_q <= 1'b0;
            s_data_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
            ready_q   <= !s_valid_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = m_valid_q;
    assign out_data  = m_data_q;

endmodule
`default_nettype wire

// File: rtl/adder_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : adder_result_stage
// Description : Registered adder output stage: saturation, status flags,
//               skid-buffered handshake and saturating overflow counter.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_result_stage
    import adder_pkg::*;
#(
    parameter int WIDTH  = ADDER_WIDTH,
    parameter bit SAT_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_cout,
    input  logic             in_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
    output logic             out_overflow,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_sat,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] ovf_count
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    result_beat_t     w_in_beat;
    result_beat_t     w_out_beat;
    logic             w_sat;
    logic             w_accept;
    logic [CNT_W-1:0] ovf_count_q, ovf_count_d;

    assign w_sat    = SAT_EN & in_overflow;
    assign w_accept = in_valid & in_ready;

    // A wrapped sum has the opposite sign of the true result, so a negative
    // wrapped sum means the true value overflowed upward.
    always_comb begin
        w_in_beat          = '0;
        w_in_beat.result   = w_sat ? (in_sum[WIDTH-1] ? SAT_MAX : SAT_MIN) : in_sum;
        w_in_beat.cout     = in_cout;
        w_in_beat.overflow = in_overflow;
        w_in_beat.sat      = w_sat;
        w_in_beat.zero     = (w_in_beat.result == '0);
        w_in_beat.neg      = w_in_beat.result[WIDTH-1];
    end

    result_skid_buffer #(
        .DATA_W (BEAT_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_beat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_beat)
    );

    assign out_result   = w_out_beat.result;
    assign out_cout     = w_out_beat.cout;
    assign out_overflow = w_out_beat.overflow;
    assign out_zero     = w_out_beat.zero;
    assign out_neg      = w_out_beat.neg;
    assign out_sat      = w_out_beat.sat;

    always_comb begin
        ovf_count_d = ovf_count_q;
        if (cnt_clr) begin
            ovf_count_d = '0;
        end else if (w_accept && in_overflow && (ovf_count_q != c_cnt_max)) begin
            ovf_count_d = ovf_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count_q <= '0;
        end else begin
            ovf_count_q <= ovf_count_d;
        end
    end

    assign ovf_count = ovf_count_q;

endmodule
`default_nettype wire
